q_meter: RTL and testbench
==========================

Name: q_meter

Overview:
Measurement front-end that answers the Q-tuning controllers (secant/bisection). It watches the controller's i_ref output, waits a settling interval after every change, then averages a burst of ADC Q-samples. It presents the averaged result on q_measured and holds ready high until i_ref changes again. It is the producer side of the controller's ready/q_measured handshake.

Parameters:
BUS_WIDTH, 10, width of i_ref, ADC samples and q_measured
SETTLE_CYCLES, 16, clocks to wait after an i_ref change before sampling (>=1)
LOG2_SAMPLES, 3, log2 of samples averaged per measurement (8 by default, >=0)
TIMEOUT_CYCLES, 64, max clocks in ACQUIRE without an accepted sample before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
i_ref  in  BUS_WIDTH  current reference from controller
sample_valid  in  1  ADC sample strobe, one sample per high cycle
sample_data  in  BUS_WIDTH  ADC Q sample, unsigned
q_measured  out  BUS_WIDTH  averaged Q for the latched i_ref, registered
ready  out  1  level flag: q_measured valid for current i_ref
busy  out  1  measurement in progress (SETTLE or ACQUIRE)
overrange  out  1  a sample in this measurement equalled 2**BUS_WIDTH-1
timeout  out  1  measurement aborted by TIMEOUT_CYCLES

Behaviour:
- Reset, while rst=1 at a clock edge:
  - q_measured=0, ready=0, overrange=0, timeout=0, busy=1.
  - State=SETTLE; ref_latch<=i_ref; all counters and the accumulator cleared.
- States: SETTLE, ACQUIRE, DONE. busy=1 in SETTLE/ACQUIRE, 0 in DONE. ready=1 only in DONE. All outputs are registered.
- SETTLE:
  - Settle counter increments every clock.
  - After exactly SETTLE_CYCLES clocks in SETTLE, go to ACQUIRE with accumulator=0, sample count=0, idle counter=0.
  - sample_valid is ignored in SETTLE.
- ACQUIRE:
  - Each cycle with sample_valid=1: acc += sample_data, count += 1, idle counter cleared.
  - If sample_data == 2**BUS_WIDTH-1, set a sticky overrange_pending bit.
  - Accumulator width is BUS_WIDTH+LOG2_SAMPLES; it never overflows.
  - On the edge that accepts sample number 2**LOG2_SAMPLES, go to DONE.
    - q_measured <= (acc + sample_data) >> LOG2_SAMPLES, i.e. floor average, always fits BUS_WIDTH.
    - ready<=1, overrange<=overrange_pending (including this sample), timeout<=0.
  - Each cycle with sample_valid=0, the idle counter increments. When it reaches TIMEOUT_CYCLES, go to DONE with q_measured<=0, ready<=1, timeout<=1, overrange<=overrange_pending.
- DONE: holds all outputs. sample_valid is ignored.
- i_ref change detection:
  - Every cycle, compare i_ref against ref_latch.
  - On a mismatch in any state, on that edge: ref_latch<=i_ref, state<=SETTLE, counters, accumulator and overrange_pending cleared, ready<=0, overrange<=0, timeout<=0.
  - q_measured holds its old value; it is don't-care while ready=0.
  - A mismatch takes priority over sample acceptance and over the DONE transition in the same cycle. That sample is discarded and no result is published.
- Latency: with sample_valid continuously high and i_ref stable, ready rises SETTLE_CYCLES + 2**LOG2_SAMPLES clocks after the change edge (24 by default).
- Handshake contract: the controller may read q_measured whenever ready=1. ready falls on the first edge after i_ref differs from the measured value. There is no other acknowledge.
- Reset mid-measurement: reset overrides everything and restarts SETTLE using the i_ref present at the reset edge.

Test Plan:
- Reset, i_ref=1023, sample_valid=1 every cycle, sample_data=65 -> busy=1 for 24 clocks after rst falls; then ready=1, q_measured=65, overrange=0, timeout=0.
- Burst 40,41,...,47 in ACQUIRE -> sum 348, q_measured=43, ready rises on the edge accepting 47.
- i_ref 1023 -> 512 after 4 of 8 samples (values 100), then 8 samples of 30 -> ready stays 0 throughout, settle restarts (16 clocks), final q_measured=30 (no 100s mixed in).
- In DONE with q_measured=65, i_ref changes to 700 -> ready=0 on that edge, busy=1; after settle plus 8 samples of 40, ready=1, q_measured=40.
- One sample = 1023 among seven samples = 1000 -> q_measured=1002 (8023>>3), overrange=1; next measurement with clean samples -> overrange=0.
- ACQUIRE with sample_valid held 0 for 64 clocks -> ready=1, timeout=1, q_measured=0. rst pulsed mid-ACQUIRE -> ready=0, q_measured=0, settle restarts.

Source files
------------

// File: rtl/q_meter.sv
// rtl/q_meter.sv - settle-then-average Q measurement front-end for the Q-tuning controllers
module q_meter #(
   parameter int BUS_WIDTH      = 10,
   parameter int SETTLE_CYCLES  = 16,
   parameter int LOG2_SAMPLES   = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic                 sample_valid,
   input  logic [BUS_WIDTH-1:0] sample_data,
   output logic [BUS_WIDTH-1:0] q_measured,
   output logic                 ready,
   output logic                 busy,
   output logic                 overrange,
   output logic                 timeout
);

   localparam int ACC_W  = BUS_WIDTH + LOG2_SAMPLES;
   localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W  = LOG2_SAMPLES + 1;

   localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [IDLE_W-1:0]    IDLE_LIMIT  = IDLE_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]     LAST_SAMPLE = CNT_W'((1 << LOG2_SAMPLES) - 1);
   localparam logic [BUS_WIDTH-1:0] FULL_SCALE  = '1;

   typedef enum logic [1:0] {
      ST_SETTLE  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [BUS_WIDTH-1:0] ref_latch_q, ref_latch_d;
   logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
   logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
   logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic                 ovr_pending_q, ovr_pending_d;
   logic [BUS_WIDTH-1:0] q_measured_q, q_measured_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 overrange_q, overrange_d;
   logic                 timeout_q, timeout_d;

   logic                 ref_changed;
   logic                 sample_full;
   logic [ACC_W-1:0]     acc_sum;
   logic [IDLE_W-1:0]    idle_next;

   assign ref_changed = (i_ref != ref_latch_q);
   assign sample_full = (sample_data == FULL_SCALE);
   // The accumulator is sized for 2**LOG2_SAMPLES full-scale samples, so this never wraps.
   assign acc_sum     = acc_q + ACC_W'(sample_data);
   assign idle_next   = idle_cnt_q + IDLE_W'(1);

   always_comb begin
      state_d       = state_q;
      ref_latch_d   = ref_latch_q;
      settle_cnt_d  = settle_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      sample_cnt_d  = sample_cnt_q;
      acc_d         = acc_q;
      ovr_pending_d = ovr_pending_q;
      q_measured_d  = q_measured_q;
      ready_d       = ready_q;
      busy_d        = busy_q;
      overrange_d   = overrange_q;
      timeout_d     = timeout_q;

      // A new reference wins over everything; any in-flight sample is dropped.
      if (ref_changed) begin
         ref_latch_d   = i_ref;
         state_d       = ST_SETTLE;
         settle_cnt_d  = '0;
         idle_cnt_d    = '0;
         sample_cnt_d  = '0;
         acc_d         = '0;
         ovr_pending_d = 1'b0;
         ready_d       = 1'b0;
         busy_d        = 1'b1;
         overrange_d   = 1'b0;
         timeout_d     = 1'b0;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  state_d      = ST_ACQUIRE;
                  settle_cnt_d = '0;
                  idle_cnt_d   = '0;
                  sample_cnt_d = '0;
                  acc_d        = '0;
               end else begin
                  settle_cnt_d = settle_cnt_q + SET_W'(1);
               end
            end
            ST_ACQUIRE: begin
               if (sample_valid) begin
                  acc_d        = acc_sum;
                  sample_cnt_d = sample_cnt_q + CNT_W'(1);
                  idle_cnt_d   = '0;
                  if (sample_full) begin
                     ovr_pending_d = 1'b1;
                  end
                  if (sample_cnt_q == LAST_SAMPLE) begin
                     state_d      = ST_DONE;
                     q_measured_d = BUS_WIDTH'(acc_sum >> LOG2_SAMPLES);
                     ready_d      = 1'b1;
                     busy_d       = 1'b0;
                     overrange_d  = ovr_pending_q | sample_full;
                     timeout_d    = 1'b0;
                  end
               end else begin
                  idle_cnt_d = idle_next;
                  if (idle_next == IDLE_LIMIT) begin
                     state_d      = ST_DONE;
                     q_measured_d = '0;
                     ready_d      = 1'b1;
                     busy_d       = 1'b0;
                     overrange_d  = ovr_pending_q;
                     timeout_d    = 1'b1;
                  end
               end
            end
            ST_DONE: begin
            end
            default: begin
               state_d = ST_SETTLE;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_SETTLE;
         ref_latch_q   <= i_ref;
         settle_cnt_q  <= '0;
         idle_cnt_q    <= '0;
         sample_cnt_q  <= '0;
         acc_q         <= '0;
         ovr_pending_q <= 1'b0;
         q_measured_q  <= '0;
         ready_q       <= 1'b0;
         busy_q        <= 1'b1;
         overrange_q   <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ref_latch_q   <= ref_latch_d;
         settle_cnt_q  <= settle_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         sample_cnt_q  <= sample_cnt_d;
         acc_q         <= acc_d;
         ovr_pending_q <= ovr_pending_d;
         q_measured_q  <= q_measured_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
         overrange_q   <= overrange_d;
         timeout_q     <= timeout_d;
      end
   end

   assign q_measured = q_measured_q;
   assign ready      = ready_q;
   assign busy       = busy_q;
   assign overrange  = overrange_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_q_meter.sv
// tb/tb_q_meter.sv - directed self-checking bench for q_meter
module tb_q_meter;

   logic       clk;
   logic       rst;
   logic [9:0] i_ref;
   logic       sample_valid;
   logic [9:0] sample_data;
   logic [9:0] q_measured;
   logic       ready;
   logic       busy;
   logic       overrange;
   logic       timeout;

   int n_tests;
   int n_fail;

   q_meter dut (
      .clk          (clk),
      .rst          (rst),
      .i_ref        (i_ref),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .q_measured   (q_measured),
      .ready        (ready),
      .busy         (busy),
      .overrange    (overrange),
      .timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_wait();
      sample_valid = 1'b0;
      repeat (16) tick();
   endtask

   task automatic send(input logic [9:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; i_ref = 10'd1023; sample_valid = 1'b1; sample_data = 10'd65;
      tick(); tick();
      n_tests++;
      if ({q_measured, ready, busy, overrange, timeout} !== {10'd0, 4'b0100}) begin
         n_fail++;
         $display("FAIL reset_state: q=%0d rdy=%b busy=%b ovr=%b to=%b, want q=0 rdy=0 busy=1 ovr=0 to=0",
                  q_measured, ready, busy, overrange, timeout);
      end
      rst = 1'b0;
      bad = 0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (busy !== 1'b1 || ready !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_busy_window: %0d of 23 cycles not busy/not-ready, want 0", bad);
      end
      tick();
      n_tests++;
      if ({q_measured, ready, busy, overrange, timeout} !== {10'd65, 4'b1000}) begin
         n_fail++;
         $display("FAIL reset_first_result: q=%0d rdy=%b busy=%b ovr=%b to=%b, want q=65 rdy=1 busy=0 ovr=0 to=0",
                  q_measured, ready, busy, overrange, timeout);
      end
   endtask

   task automatic test_ramp_average();
      i_ref = 10'd500; sample_valid = 1'b0;
      tick();
      n_tests++;
      if ({ready, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL ramp_change_edge: rdy=%b busy=%b, want rdy=0 busy=1", ready, busy);
      end
      settle_wait();
      for (int v = 40; v <= 46; v++) send(10'(v));
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ramp_before_last: rdy=%b, want 0", ready);
      end
      send(10'd47);
      n_tests++;
      if ({q_measured, ready} !== {10'd43, 1'b1}) begin
         n_fail++;
         $display("FAIL ramp_average: q=%0d rdy=%b, want q=43 rdy=1", q_measured, ready);
      end
   endtask

   task automatic test_change_mid_acquire();
      int bad;
      i_ref = 10'd1023;
      tick();
      settle_wait();
      repeat (4) send(10'd100);
      i_ref = 10'd512; sample_valid = 1'b1; sample_data = 10'd100;
      tick();
      n_tests++;
      if ({ready, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL mid_change_edge: rdy=%b busy=%b, want rdy=0 busy=1", ready, busy);
      end
      sample_data = 10'd30;
      bad = 0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (ready !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL mid_restart_window: ready high on %0d of 23 cycles, want 0", bad);
      end
      tick();
      sample_valid = 1'b0;
      n_tests++;
      if ({q_measured, ready} !== {10'd30, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_restart_result: q=%0d rdy=%b, want q=30 rdy=1", q_measured, ready);
      end
   endtask

   task automatic test_change_in_done();
      i_ref = 10'd300;
      tick();
      settle_wait();
      repeat (8) send(10'd65);
      n_tests++;
      if ({q_measured, ready} !== {10'd65, 1'b1}) begin
         n_fail++;
         $display("FAIL done_setup: q=%0d rdy=%b, want q=65 rdy=1", q_measured, ready);
      end
      i_ref = 10'd700;
      tick();
      n_tests++;
      if ({ready, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL done_change_edge: rdy=%b busy=%b, want rdy=0 busy=1", ready, busy);
      end
      settle_wait();
      repeat (8) send(10'd40);
      n_tests++;
      if ({q_measured, ready, busy} !== {10'd40, 2'b10}) begin
         n_fail++;
         $display("FAIL done_new_result: q=%0d rdy=%b busy=%b, want q=40 rdy=1 busy=0", q_measured, ready, busy);
      end
   endtask

   task automatic test_overrange();
      i_ref = 10'd100;
      tick();
      settle_wait();
      repeat (3) send(10'd1000);
      send(10'd1023);
      repeat (4) send(10'd1000);
      n_tests++;
      if ({q_measured, ready, overrange, timeout} !== {10'd1002, 3'b110}) begin
         n_fail++;
         $display("FAIL ovr_mid_sample: q=%0d rdy=%b ovr=%b to=%b, want q=1002 rdy=1 ovr=1 to=0",
                  q_measured, ready, overrange, timeout);
      end
      i_ref = 10'd101;
      tick();
      n_tests++;
      if ({ready, overrange} !== 2'b00) begin
         n_fail++;
         $display("FAIL ovr_cleared_on_change: rdy=%b ovr=%b, want rdy=0 ovr=0", ready, overrange);
      end
      settle_wait();
      repeat (8) send(10'd200);
      n_tests++;
      if ({q_measured, ready, overrange} !== {10'd200, 2'b10}) begin
         n_fail++;
         $display("FAIL ovr_clean_next: q=%0d rdy=%b ovr=%b, want q=200 rdy=1 ovr=0", q_measured, ready, overrange);
      end
      i_ref = 10'd99;
      tick();
      settle_wait();
      repeat (7) send(10'd0);
      send(10'd1023);
      n_tests++;
      if ({q_measured, ready, overrange} !== {10'd127, 2'b11}) begin
         n_fail++;
         $display("FAIL ovr_last_sample: q=%0d rdy=%b ovr=%b, want q=127 rdy=1 ovr=1", q_measured, ready, overrange);
      end
   endtask

   task automatic test_timeout();
      i_ref = 10'd102;
      tick();
      settle_wait();
      sample_valid = 1'b0;
      repeat (63) tick();
      n_tests++;
      if ({ready, busy, timeout} !== 3'b010) begin
         n_fail++;
         $display("FAIL timeout_early: rdy=%b busy=%b to=%b after 63 idle, want rdy=0 busy=1 to=0", ready, busy, timeout);
      end
      tick();
      n_tests++;
      if ({q_measured, ready, busy, timeout, overrange} !== {10'd0, 4'b1010}) begin
         n_fail++;
         $display("FAIL timeout_fire: q=%0d rdy=%b busy=%b to=%b ovr=%b, want q=0 rdy=1 busy=0 to=1 ovr=0",
                  q_measured, ready, busy, timeout, overrange);
      end
      i_ref = 10'd103;
      tick();
      n_tests++;
      if ({ready, busy, timeout} !== 3'b010) begin
         n_fail++;
         $display("FAIL timeout_cleared: rdy=%b busy=%b to=%b, want rdy=0 busy=1 to=0", ready, busy, timeout);
      end
   endtask

   task automatic test_gapped_samples();
      i_ref = 10'd105;
      tick();
      settle_wait();
      for (int i = 0; i < 8; i++) begin
         send(10'(i * 10));
         if (i < 7) repeat (63) tick();
      end
      n_tests++;
      if ({q_measured, ready, timeout} !== {10'd35, 2'b10}) begin
         n_fail++;
         $display("FAIL gapped_average: q=%0d rdy=%b to=%b, want q=35 rdy=1 to=0", q_measured, ready, timeout);
      end
   endtask

   task automatic test_reset_mid_acquire();
      int bad;
      i_ref = 10'd106;
      tick();
      settle_wait();
      repeat (3) send(10'd500);
      rst = 1'b1; i_ref = 10'd107; sample_valid = 1'b1; sample_data = 10'd77;
      tick();
      n_tests++;
      if ({q_measured, ready, busy, timeout} !== {10'd0, 3'b010}) begin
         n_fail++;
         $display("FAIL reset_mid: q=%0d rdy=%b busy=%b to=%b, want q=0 rdy=0 busy=1 to=0",
                  q_measured, ready, busy, timeout);
      end
      rst = 1'b0;
      bad = 0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (ready !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_window: ready high on %0d of 23 cycles, want 0", bad);
      end
      tick();
      sample_valid = 1'b0;
      n_tests++;
      if ({q_measured, ready} !== {10'd77, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_result: q=%0d rdy=%b, want q=77 rdy=1", q_measured, ready);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; i_ref = '0; sample_valid = 1'b0; sample_data = '0;
      test_reset();
      test_ramp_average();
      test_change_mid_acquire();
      test_change_in_done();
      test_overrange();
      test_timeout();
      test_gapped_samples();
      test_reset_mid_acquire();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
